uhci_frame_scheduler: RTL and testbench
=======================================

Name: uhci_frame_scheduler

Overview:
- Sequences per-frame host controller operation from the Run/Stop bit held in the register file.
- Maintains the frame timer and generates the frame number F_no and the SOF-side halt status, both written back into the register file.
- Each frame: fetches the frame-list entry at {FLBASEADD, F_no} through a request/acknowledge handshake, then launches and supervises the transaction engine.
- Sits between the register file, the frame-list memory port and the transaction FSM.

Parameters:
- FRAME_CYCLES, 64: clock cycles per frame (minimum 8).
- CNT_W, 7: frame timer width; must satisfy 2^CNT_W >= FRAME_CYCLES.
- PTR_W, 8: width of a frame-list pointer.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- RS  in  1  Run/Stop from register file.
- FLBASEADD  in  2  frame-list base address from register file.
- F_no  out  4  current frame number, to register file.
- HCR_halt_sof  out  1  controller halted, to register file.
- sof_pulse  out  1  one-cycle start-of-frame strobe.
- fl_req  out  1  frame-list fetch request.
- fl_addr  out  6  fetch address {FLBASEADD, F_no}.
- fl_ack  in  1  fetch complete; fl_ptr and fl_term valid this cycle.
- fl_ptr  in  PTR_W  frame-list pointer.
- fl_term  in  1  terminate bit of the entry.
- td_start  out  1  one-cycle start to the transaction FSM.
- td_ptr  out  PTR_W  pointer latched at fl_ack.
- td_done  in  1  transaction FSM finished the frame.
- frame_overrun  out  1  one-cycle pulse: frame boundary reached while FETCH/EXEC is busy.

Behaviour:
- Reset values: state HALTED, F_no=0, HCR_halt_sof=1, timer=0, all pulses=0, fl_req=0, fl_addr=0, td_ptr=0.
- States: HALTED, SOF, FETCH, EXEC, WAIT_EOF.
- Frame timer:
  - Counts only outside HALTED; 0..FRAME_CYCLES-1, then wraps to 0.
  - The cycle with timer==FRAME_CYCLES-1 is the frame tick.
  - On the tick, F_no <= F_no+1 mod 16 (15 wraps to 0).
- HALTED:
  - Timer held at 0; HCR_halt_sof=1.
  - RS=1 sampled -> next cycle SOF, HCR_halt_sof=0, timer starts at 0.
  - F_no is retained across halts (no clear except reset).
- SOF:
  - sof_pulse=1 for exactly one cycle, then FETCH.
  - If RS=0 here -> HALTED instead (sof_pulse still issued).
- FETCH:
  - fl_req=1; fl_addr={FLBASEADD, F_no} registered on FETCH entry and stable until ack.
  - fl_req stays high until the fl_ack cycle and deasserts the next cycle; the request is never withdrawn early.
  - On fl_ack: td_ptr<=fl_ptr.
  - fl_term=1 -> WAIT_EOF, no td_start.
  - fl_term=0 -> EXEC, with td_start=1 on the first EXEC cycle only.
- EXEC: wait for td_done, then WAIT_EOF.
- WAIT_EOF:
  - On the frame tick: RS=1 -> SOF; RS=0 -> HALTED.
  - td_done arriving in WAIT_EOF is ignored.
- Overrun:
  - Frame tick in FETCH or EXEC: frame_overrun=1 for one cycle; F_no still increments.
  - The active handshake completes normally; at its completion the FSM goes directly to SOF (RS=1) or HALTED (RS=0), skipping WAIT_EOF.
  - Repeated ticks during the same stall pulse frame_overrun again.
- RS drop mid-frame: FETCH/EXEC are not aborted; RS is evaluated only at the exits listed above.
- Simultaneous events:
  - fl_ack and tick in the same cycle counts as overrun; next state follows the overrun rule.
  - td_done and tick in the same cycle counts as overrun; next state follows the overrun rule.
- All outputs are registered.
- Reset mid-operation returns all outputs to reset values immediately and asynchronously.

Test Plan:
- FRAME_CYCLES=16; reset, RS=1 at cycle 5, FLBASEADD=2 -> HCR_halt_sof falls at cycle 6, sof_pulse at 7, fl_req at 8 with fl_addr=6'b100000; F_no=1 after the 16th counted cycle.
- fl_ack after 3 cycles with fl_ptr=8'hA5, fl_term=0 -> td_start one cycle, td_ptr=8'hA5; td_done after 4 cycles -> WAIT_EOF, next sof_pulse exactly 16 cycles after the previous one.
- fl_term=1 -> no td_start; next SOF at the frame boundary.
- Hold td_done low 20 cycles -> frame_overrun pulse at the tick, F_no advances; after td_done the FSM goes straight to SOF.
- Run 17 frames -> F_no sequence 0..15,0, and fl_addr low nibble tracks F_no.
- RS=0 during EXEC -> EXEC completes, HALTED at the boundary, HCR_halt_sof=1, F_no frozen; assert rst_n=0 mid-FETCH -> fl_req=0, F_no=0 immediately.

Source files
------------

// File: rtl/uhci_frame_scheduler.sv
// Purpose: per-frame host controller sequencer. It runs the frame timer, the frame number and
//          the halt status, fetches the frame-list entry and then launches the transaction engine.
// Latency: all outputs are registered. sof_pulse follows SOF entry by one cycle, and fl_req
//          follows FETCH entry by one cycle.
// Backpressure: the fetch waits on fl_ack and the execution waits on td_done, with no abort.
//          A frame tick that arrives while busy raises a frame_overrun pulse.
// Ports:  clk/rst_n       clock and asynchronous active-low reset
//         RS, FLBASEADD   run/stop bit and frame-list base address from the register file
//         F_no, HCR_halt_sof  frame number and halt status back to the register file
//         sof_pulse       one-cycle start-of-frame strobe
//         fl_req/fl_addr/fl_ack/fl_ptr/fl_term  frame-list fetch handshake
//         td_start/td_ptr/td_done               transaction FSM launch and completion
//         frame_overrun   one-cycle pulse when a frame boundary hits a busy FETCH or EXEC
module uhci_frame_scheduler #(
  parameter int FRAME_CYCLES = 64,
  parameter int CNT_W        = 7,
  parameter int PTR_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RS,
  input  logic [1:0]       FLBASEADD,
  output logic [3:0]       F_no,
  output logic             HCR_halt_sof,
  output logic             sof_pulse,
  output logic             fl_req,
  output logic [5:0]       fl_addr,
  input  logic             fl_ack,
  input  logic [PTR_W-1:0] fl_ptr,
  input  logic             fl_term,
  output logic             td_start,
  output logic [PTR_W-1:0] td_ptr,
  input  logic             td_done,
  output logic             frame_overrun
);

  typedef enum logic [2:0] {S_HALTED, S_SOF, S_FETCH, S_EXEC, S_WAIT_EOF} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [3:0]       f_no_q, f_no_d;
  logic             halt_q, halt_d;
  logic             sof_q, sof_d;
  logic             fl_req_q, fl_req_d;
  logic [5:0]       fl_addr_q, fl_addr_d;
  logic             td_start_q, td_start_d;
  logic [PTR_W-1:0] td_ptr_q, td_ptr_d;
  logic             ovr_pulse_q, ovr_pulse_d;
  logic             ovr_q, ovr_d;   // an overrun already happened during this FETCH/EXEC

  logic   tick, busy, ovr_tick, ovr_any, ack;
  state_t exit_st;

  assign tick     = (state_q != S_HALTED) && (timer_q == CNT_W'(FRAME_CYCLES - 1));
  assign busy     = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign ovr_tick = tick && busy;
  assign ovr_any  = ovr_q || ovr_tick;
  // An acknowledge counts only while the request is visible on the port.
  assign ack      = (state_q == S_FETCH) && fl_req_q && fl_ack;
  assign exit_st  = RS ? S_SOF : S_HALTED;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_HALTED;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HALTED:   if (RS) state_d = S_SOF;
      S_SOF:      state_d = RS ? S_FETCH : S_HALTED;
      S_FETCH:    if (ack) begin
                    if (ovr_any)      state_d = exit_st;   // overrun: skip the rest of the frame
                    else if (fl_term) state_d = S_WAIT_EOF;
                    else              state_d = S_EXEC;
                  end
      S_EXEC:     if (td_done) state_d = ovr_any ? exit_st : S_WAIT_EOF;
      S_WAIT_EOF: if (tick) state_d = exit_st;
      default:    state_d = S_HALTED;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    // Hold the timer at 0 in HALTED and on the way into it, so SOF always starts at 0.
    if (state_q == S_HALTED || state_d == S_HALTED) timer_d = '0;
    else if (tick)                                  timer_d = '0;
    else                                            timer_d = timer_q + CNT_W'(1);
    f_no_d      = tick ? f_no_q + 4'd1 : f_no_q;
    halt_d      = (state_d == S_HALTED);
    sof_d       = (state_q == S_SOF);
    fl_req_d    = (state_q == S_FETCH) && !ack;
    // Latch the address on FETCH entry, using the frame number that the fetch will see.
    fl_addr_d   = (state_d == S_FETCH && state_q != S_FETCH) ? {FLBASEADD, f_no_d} : fl_addr_q;
    td_ptr_d    = ack ? fl_ptr : td_ptr_q;
    td_start_d  = (state_q == S_FETCH) && (state_d == S_EXEC);
    ovr_pulse_d = ovr_tick;
    ovr_d       = ((state_d == S_FETCH) || (state_d == S_EXEC)) && ovr_any;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q     <= '0;
      f_no_q      <= 4'd0;
      halt_q      <= 1'b1;
      sof_q       <= 1'b0;
      fl_req_q    <= 1'b0;
      fl_addr_q   <= 6'd0;
      td_start_q  <= 1'b0;
      td_ptr_q    <= '0;
      ovr_pulse_q <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      f_no_q      <= f_no_d;
      halt_q      <= halt_d;
      sof_q       <= sof_d;
      fl_req_q    <= fl_req_d;
      fl_addr_q   <= fl_addr_d;
      td_start_q  <= td_start_d;
      td_ptr_q    <= td_ptr_d;
      ovr_pulse_q <= ovr_pulse_d;
      ovr_q       <= ovr_d;
    end
  end

  assign F_no          = f_no_q;
  assign HCR_halt_sof  = halt_q;
  assign sof_pulse     = sof_q;
  assign fl_req        = fl_req_q;
  assign fl_addr       = fl_addr_q;
  assign td_start      = td_start_q;
  assign td_ptr        = td_ptr_q;
  assign frame_overrun = ovr_pulse_q;

endmodule

// File: tb/tb_uhci_frame_scheduler.sv
// Directed bench for uhci_frame_scheduler with FRAME_CYCLES=16.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Expected cycle numbers are counted from the edge that samples RS=1.
module tb_uhci_frame_scheduler;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       RS;
  logic [1:0] FLBASEADD;
  logic [3:0] F_no;
  logic       HCR_halt_sof, sof_pulse, fl_req, fl_ack, fl_term, td_start, td_done, frame_overrun;
  logic [5:0] fl_addr;
  logic [7:0] fl_ptr, td_ptr;

  int checks = 0;
  int failures = 0;
  int sof_cnt, st_cnt, ov_cnt;
  int n;
  logic [5:0] exp_addr;

  uhci_frame_scheduler #(.FRAME_CYCLES(16), .CNT_W(4), .PTR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .RS(RS), .FLBASEADD(FLBASEADD), .F_no(F_no),
    .HCR_halt_sof(HCR_halt_sof), .sof_pulse(sof_pulse), .fl_req(fl_req), .fl_addr(fl_addr),
    .fl_ack(fl_ack), .fl_ptr(fl_ptr), .fl_term(fl_term), .td_start(td_start), .td_ptr(td_ptr),
    .td_done(td_done), .frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Advance one cycle and tally the strobes seen.
  task automatic step();
    @(posedge clk);
    #1;
    if (sof_pulse)     sof_cnt++;
    if (td_start)      st_cnt++;
    if (frame_overrun) ov_cnt++;
  endtask

  task automatic stepn(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  // Returns the number of cycles until sof_pulse is seen, or -1 on timeout.
  task automatic wait_sof(input int max, output int cnt);
    cnt = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (sof_pulse) begin cnt = i; break; end
    end
  endtask

  task automatic wait_req(input int max, output int cnt);
    cnt = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (fl_req) begin cnt = i; break; end
    end
  endtask

  task automatic ack(input logic [7:0] p, input logic t);
    fl_ack = 1'b1; fl_ptr = p; fl_term = t;
    step();
    fl_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; RS = 1'b0; FLBASEADD = 2'd0; fl_ack = 1'b0; fl_ptr = 8'h00;
    fl_term = 1'b0; td_done = 1'b0;
    sof_cnt = 0; st_cnt = 0; ov_cnt = 0;
    stepn(2);
    rst_n = 1'b1;
    step();
    chk("rst_halt", HCR_halt_sof, 1);
    chk("rst_sof", sof_pulse, 0);
    chk("rst_req", fl_req, 0);
    chk("rst_fno", F_no, 0);
    chk("rst_addr", fl_addr, 0);
    chk("rst_tdptr", td_ptr, 0);
    chk("rst_ovr", frame_overrun, 0);

    // Frame 0: start, fetch with term=0, execute.
    RS = 1'b1; FLBASEADD = 2'd2;
    step();                                   // E1
    chk("e1_halt", HCR_halt_sof, 0);
    chk("e1_sof", sof_pulse, 0);
    step();                                   // E2
    chk("e2_sof", sof_pulse, 1);
    chk("e2_addr", fl_addr, 6'b100000);
    chk("e2_req", fl_req, 0);
    step();                                   // E3
    chk("e3_sof", sof_pulse, 0);
    chk("e3_req", fl_req, 1);
    stepn(2);                                 // E5
    chk("e5_req_held", fl_req, 1);
    ack(8'hA5, 1'b0);                         // E6
    chk("e6_tdstart", td_start, 1);
    chk("e6_tdptr", td_ptr, 8'hA5);
    chk("e6_req_drop", fl_req, 0);
    step();                                   // E7
    chk("e7_tdstart_off", td_start, 0);
    stepn(2);                                 // E9
    td_done = 1'b1;
    step();                                   // E10
    td_done = 1'b0;
    wait_sof(30, n);                          // expect E18
    chk("f1_sof_delay", n, 8);
    chk("f1_fno", F_no, 1);
    chk("f1_addr", fl_addr, 6'b100001);

    // Frame 1: terminate bit set, so no td_start.
    step();                                   // E19
    chk("f1_req", fl_req, 1);
    st_cnt = 0;
    ack(8'h11, 1'b1);                         // E20
    chk("f1_tdptr", td_ptr, 8'h11);
    wait_sof(30, n);                          // expect E34
    chk("f2_sof_delay", n, 14);
    chk("f1_no_tdstart", st_cnt, 0);
    chk("f2_fno", F_no, 2);

    // Frame 2: td_done held low past the boundary.
    step();                                   // E35
    ack(8'h3C, 1'b0);                         // E36
    chk("f2_tdstart", td_start, 1);
    ov_cnt = 0; sof_cnt = 0;
    stepn(20);                                // E56
    chk("ovr_pulses", ov_cnt, 1);
    chk("ovr_fno", F_no, 3);
    chk("ovr_no_sof", sof_cnt, 0);
    td_done = 1'b1;
    step();                                   // E57
    td_done = 1'b0;
    wait_sof(20, n);
    chk("ovr_direct_sof", n, 1);
    chk("ovr_sof_fno", F_no, 3);

    // Reset, then 17 frames with term=1: F_no 0..15,0.
    rst_n = 1'b0;
    stepn(2);
    rst_n = 1'b1;
    FLBASEADD = 2'd1;
    for (int i = 0; i < 17; i++) begin
      wait_sof(40, n);
      chk("loop_sof_seen", int'(n > 0), 1);
      chk("loop_fno", F_no, i % 16);
      wait_req(10, n);
      exp_addr = {2'd1, 4'(i % 16)};
      chk("loop_addr", fl_addr, exp_addr);
      ack(8'h00, 1'b1);
    end

    // RS drops during EXEC: finish the frame and halt at the boundary.
    wait_sof(40, n);
    wait_req(10, n);
    ack(8'h5A, 1'b0);
    RS = 1'b0;
    stepn(3);
    td_done = 1'b1;
    step();
    td_done = 1'b0;
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (HCR_halt_sof) begin n = i; break; end
    end
    chk("halt_seen", int'(n > 0), 1);
    chk("halt_fno", F_no, 2);
    chk("halt_tdptr", td_ptr, 8'h5A);
    sof_cnt = 0;
    stepn(20);
    chk("halt_no_sof", sof_cnt, 0);
    chk("halt_fno_frozen", F_no, 2);
    chk("halt_req", fl_req, 0);

    // Restart keeps F_no; then reset in the middle of the fetch.
    RS = 1'b1;
    wait_sof(10, n);
    chk("restart_sof", n, 2);
    chk("restart_fno", F_no, 2);
    wait_req(10, n);
    chk("restart_req", fl_req, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_req", fl_req, 0);
    chk("arst_fno", F_no, 0);
    chk("arst_halt", HCR_halt_sof, 1);
    chk("arst_addr", fl_addr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
